hamming_window: RTL and testbench



---
 rtl/hamming_window_pkg.sv | 31 +++
 rtl/hamming_coeff_rom.sv | 27 ++
 rtl/hamming_window.sv | 74 +++++++
 tb/tb_hamming_window.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_window_pkg.sv
// Shared DSP constants and elaboration-time helpers for the Hamming window stage.
package hamming_window_pkg;

  localparam int  Q_FRAC        = 15;
  localparam real HAMMING_ALPHA = 0.54;
  localparam real HAMMING_BETA  = 0.46;
  localparam real TWO_PI        = 6.283185307179586;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Q1.15 Hamming coefficient, rounded to nearest and saturated just below 1.0.
  function automatic int hamming_coef(input int n, input int size);
    real w;
    int  q;
    w = HAMMING_ALPHA - HAMMING_BETA * $cos(TWO_PI * real'(n) / real'(size - 1));
    q = $rtoi(w * real'(1 << Q_FRAC) + 0.5);
    if (q > (1 << Q_FRAC) - 1) q = (1 << Q_FRAC) - 1;
    return q;
  endfunction

endpackage

// File: rtl/hamming_coeff_rom.sv
// Hamming coefficient table built at elaboration; registered read, one cycle latency.
module hamming_coeff_rom
  import hamming_window_pkg::*;
#(
  parameter int FFT_SIZE   = 1024,
  parameter int COEF_WIDTH = 16,
  localparam int AW        = clog2(FFT_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [AW-1:0]         addr,
  output logic [COEF_WIDTH-1:0] coef
);

  logic [COEF_WIDTH-1:0] rom [FFT_SIZE];

  for (genvar n = 0; n < FFT_SIZE; n++) begin : g_tab
    localparam int C = hamming_coef(n, FFT_SIZE);
    assign rom[n] = COEF_WIDTH'(C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) coef <= '0;
    else        coef <= rom[addr];
  end

endmodule

// File: rtl/hamming_window.sv
// Streaming Hamming window: frame index counter, coefficient lookup and a
// two-stage multiply pipeline ahead of the FFT.
module hamming_window
  import hamming_window_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int FFT_SIZE   = 1024,
  parameter int COEF_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             output_valid
);

  localparam int IW = clog2(FFT_SIZE);
  localparam int PW = WIDTH + COEF_WIDTH + 1;

  logic [IW-1:0]         idx;
  logic [COEF_WIDTH-1:0] coef_s1;
  logic signed [WIDTH-1:0] data_s1;
  logic                  valid_s1;
  logic signed [PW-1:0]  data_ext;
  logic signed [PW-1:0]  coef_ext;
  logic signed [PW-1:0]  product;

  // Frame position only advances on accepted samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (data_valid) begin
      if (idx == IW'(FFT_SIZE - 1)) idx <= '0;
      else                          idx <= idx + IW'(1);
    end
  end

  hamming_coeff_rom #(
    .FFT_SIZE  (FFT_SIZE),
    .COEF_WIDTH(COEF_WIDTH)
  ) u_rom (
    .clk  (clk),
    .rst_n(rst_n),
    .addr (idx),
    .coef (coef_s1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_s1  <= '0;
      valid_s1 <= 1'b0;
    end else begin
      data_s1  <= data_in;
      valid_s1 <= data_valid;
    end
  end

  // Coefficient is unsigned, so it is zero-extended before the signed multiply.
  assign data_ext = PW'(data_s1);
  assign coef_ext = PW'({1'b0, coef_s1});
  assign product  = data_ext * coef_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out     <= '0;
      output_valid <= 1'b0;
    end else begin
      output_valid <= valid_s1;
      if (valid_s1) data_out <= WIDTH'(product >>> Q_FRAC);
    end
  end

endmodule

// File: tb/tb_hamming_window.sv
// Randomized and directed bench for hamming_window against a real-arithmetic window model.
module tb_hamming_window;

  localparam int W  = 32;
  localparam int N  = 64;
  localparam int CW = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         data_valid = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] data_out;
  logic         output_valid;

  int           n_vec = 0;
  int           n_err = 0;
  int           midx = 0;
  logic         pend_v = 1'b0;
  logic         exp_ov = 1'b0;
  logic [W-1:0] last_out = '0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got[$];

  hamming_window #(.WIDTH(W), .FFT_SIZE(N), .COEF_WIDTH(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_out    (data_out),
    .output_valid(output_valid)
  );

  always #5 clk = ~clk;

  function automatic int ref_coef(input int n);
    real w;
    int  q;
    w = 0.54 - 0.46 * $cos(2.0 * 3.141592653589793 * n / (N - 1));
    q = int'(w * 32768.0);
    return (q > 32767) ? 32767 : q;
  endfunction

  function automatic logic [W-1:0] ref_out(input logic [W-1:0] d, input int n);
    longint p;
    p = longint'($signed(d)) * longint'(ref_coef(n));
    return W'(p >>> 15);
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    got.delete();
    midx = 0;
    pend_v = 1'b0;
    exp_ov = 1'b0;
    last_out = '0;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    data_valid = 1'b0;
    data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  // Drive one clock of input and advance the model; output seen #1 after the edge
  // belongs to the sample accepted one edge earlier.
  task automatic tick(input logic v, input logic [W-1:0] d);
    data_valid = v;
    data_in = d;
    @(posedge clk);
    exp_ov = pend_v;
    pend_v = v;
    if (v) begin
      exp_q.push_back(ref_out(d, midx));
      midx = (midx + 1) % N;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [W-1:0] want, d;
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      data_valid = i[0];
      data_in = $urandom;
      @(posedge clk);
      #1;
      n_vec++;
      if (output_valid !== 1'b0 || data_out !== '0) begin
        n_err++;
        $display("FAIL reset_hold: valid=%b data=%0d, expected valid=0 data=0", output_valid, $signed(data_out));
      end
    end
    data_valid = 1'b0;
    rst_n = 1'b1;
    model_clear();
    d = $urandom;
    for (int i = 0; i < 4; i++) begin
      tick(i == 0, d);
      want = exp_ov ? exp_q.pop_front() : last_out;
      if (exp_ov) begin got.push_back(data_out); last_out = want; end
      n_vec++;
      if (output_valid !== exp_ov || data_out !== want) begin
        n_err++;
        $display("FAIL reset_first t=%0t: valid=%b data=%0d, expected valid=%b data=%0d", $time, output_valid, $signed(data_out), exp_ov, $signed(want));
      end
    end
    n_vec++;
    if (got.size() != 1 || got[0] !== ref_out(d, 0)) begin
      n_err++;
      $display("FAIL reset_coef0: outputs=%0d, expected 1 output scaled by coef[0]=%0d", got.size(), ref_coef(0));
    end
  endtask

  task automatic test_const(input int v, input int e0, input int e31);
    logic [W-1:0] want;
    apply_reset();
    for (int i = 0; i < N + 4; i++) begin
      tick(i < N, W'(v));
      want = exp_ov ? exp_q.pop_front() : last_out;
      if (exp_ov) begin got.push_back(data_out); last_out = want; end
      n_vec++;
      if (output_valid !== exp_ov || data_out !== want) begin
        n_err++;
        $display("FAIL const_stream t=%0t: valid=%b data=%0d, expected valid=%b data=%0d", $time, output_valid, $signed(data_out), exp_ov, $signed(want));
      end
    end
    n_vec++;
    if (got.size() != N || $signed(got[0]) != e0 || $signed(got[N-1]) != e0 || $signed(got[31]) != e31) begin
      n_err++;
      $display("FAIL const_points: count=%0d out0=%0d out63=%0d out31=%0d, expected count=%0d out0=%0d out63=%0d out31=%0d", got.size(), $signed(got[0]), $signed(got[N-1]), $signed(got[31]), N, e0, e0, e31);
    end
    for (int i = 0; i < N / 2; i++) begin
      n_vec++;
      if (got[i] !== got[N-1-i]) begin
        n_err++;
        $display("FAIL const_symmetry: out[%0d]=%0d out[%0d]=%0d, expected equal", i, $signed(got[i]), N-1-i, $signed(got[N-1-i]));
      end
    end
  endtask

  task automatic test_ramp();
    logic [W-1:0] want;
    apply_reset();
    for (int i = 0; i < N + 4; i++) begin
      tick(i < N, W'(i));
      want = exp_ov ? exp_q.pop_front() : last_out;
      if (exp_ov) begin got.push_back(data_out); last_out = want; end
      n_vec++;
      if (output_valid !== exp_ov || data_out !== want) begin
        n_err++;
        $display("FAIL ramp_stream t=%0t: valid=%b data=%0d, expected valid=%b data=%0d", $time, output_valid, $signed(data_out), exp_ov, $signed(want));
      end
    end
    n_vec++;
    if (got.size() != N || got[0] !== 0 || got[1] !== 0 || got[N-1] !== 5) begin
      n_err++;
      $display("FAIL ramp_points: count=%0d out0=%0d out1=%0d out63=%0d, expected 64 0 0 5", got.size(), got[0], got[1], got[N-1]);
    end
  endtask

  task automatic test_gapped();
    logic [W-1:0] want;
    apply_reset();
    for (int i = 0; i < 2 * N + 4; i++) begin
      tick((i < 2 * N) && (i % 2 == 0), W'(65536));
      want = exp_ov ? exp_q.pop_front() : last_out;
      if (exp_ov) begin got.push_back(data_out); last_out = want; end
      n_vec++;
      if (output_valid !== exp_ov || data_out !== want) begin
        n_err++;
        $display("FAIL gapped_stream t=%0t: valid=%b data=%0d, expected valid=%b data=%0d", $time, output_valid, $signed(data_out), exp_ov, $signed(want));
      end
    end
    n_vec++;
    if (got.size() != N || got[0] !== 5242 || got[31] !== 65498 || got[N-1] !== 5242) begin
      n_err++;
      $display("FAIL gapped_points: count=%0d out0=%0d out31=%0d out63=%0d, expected 64 5242 65498 5242", got.size(), got[0], got[31], got[N-1]);
    end
  endtask

  task automatic test_wrap_reset();
    logic [W-1:0] want;
    apply_reset();
    for (int i = 0; i < 74; i++) begin
      tick(i < 70, W'(65536));
      want = exp_ov ? exp_q.pop_front() : last_out;
      if (exp_ov) begin got.push_back(data_out); last_out = want; end
      n_vec++;
      if (output_valid !== exp_ov || data_out !== want) begin
        n_err++;
        $display("FAIL wrap_stream t=%0t: valid=%b data=%0d, expected valid=%b data=%0d", $time, output_valid, $signed(data_out), exp_ov, $signed(want));
      end
    end
    n_vec++;
    if (got.size() != 70 || got[64] !== 5242) begin
      n_err++;
      $display("FAIL wrap_sample64: count=%0d out64=%0d, expected 70 5242", got.size(), got[64]);
    end
    apply_reset();
    for (int i = 0; i < 11; i++) tick(1'b1, W'(65536));
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (output_valid !== 1'b0 || data_out !== '0) begin
      n_err++;
      $display("FAIL midreset_drop: valid=%b data=%0d, expected valid=0 data=0", output_valid, $signed(data_out));
    end
    data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      tick(i == 0, W'(65536));
      want = exp_ov ? exp_q.pop_front() : last_out;
      if (exp_ov) begin got.push_back(data_out); last_out = want; end
      n_vec++;
      if (output_valid !== exp_ov || data_out !== want) begin
        n_err++;
        $display("FAIL midreset_stream t=%0t: valid=%b data=%0d, expected valid=%b data=%0d", $time, output_valid, $signed(data_out), exp_ov, $signed(want));
      end
    end
    n_vec++;
    if (got.size() != 1 || got[0] !== 5242) begin
      n_err++;
      $display("FAIL midreset_coef0: count=%0d out0=%0d, expected 1 5242", got.size(), got[0]);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] want;
    apply_reset();
    for (int i = 0; i < 304; i++) begin
      tick((i < 300) && ($urandom_range(0, 3) != 0), W'($urandom));
      want = exp_ov ? exp_q.pop_front() : last_out;
      if (exp_ov) begin got.push_back(data_out); last_out = want; end
      n_vec++;
      if (output_valid !== exp_ov || data_out !== want) begin
        n_err++;
        $display("FAIL random_stream t=%0t: valid=%b data=%0d, expected valid=%b data=%0d", $time, output_valid, $signed(data_out), exp_ov, $signed(want));
      end
    end
  endtask

  initial begin
    test_reset();
    test_const(65536, 5242, 65498);
    test_const(-65536, -5242, -65498);
    test_ramp();
    test_gapped();
    test_wrap_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
